// File: rtl/npu_requant_pack.sv
// Requantize signed activations (multiply, rounding shift, saturate) and pack
// PACK lanes per output word. Output uses valid/ready, and a stalled output
// freezes the whole pipeline.
module npu_requant_pack #(
  parameter int unsigned M_LEN   = 16,
  parameter int unsigned OUT_LEN = 8,
  parameter int unsigned PACK    = 4,
  parameter int unsigned SCALE_W = 16,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [M_LEN-1:0]          data_i,
  input  logic                      valid_i,
  input  logic                      last_i,
  output logic                      ready_o,
  input  logic [SCALE_W-1:0]        scale_i,
  input  logic [SHIFT_W-1:0]        shift_i,
  output logic [PACK*OUT_LEN-1:0]   data_o,
  output logic [PACK-1:0]           keep_o,
  output logic                      last_o,
  output logic                      valid_o,
  input  logic                      ready_i
);

  localparam int unsigned PW = M_LEN + SCALE_W + 1;  // product width
  localparam int unsigned RW = PW + 1;               // rounding headroom
  localparam int unsigned CW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int unsigned WW = PACK * OUT_LEN;

  localparam logic signed [RW-1:0] QMAX = RW'((2 ** (OUT_LEN - 1)) - 1);
  localparam logic signed [RW-1:0] QMIN = -RW'(2 ** (OUT_LEN - 1));

  logic                 en;
  logic                 s1_valid_q, s1_last_q;
  logic signed [PW-1:0] s1_prod_q;
  logic                 s2_valid_q, s2_last_q;
  logic [OUT_LEN-1:0]   s2_q;
  logic [CW-1:0]        cnt_q;
  logic [WW-1:0]        acc_q;

  logic signed [PW-1:0] data_ext, scale_ext, prod_d;
  logic signed [RW-1:0] rnd, sum, shifted;
  logic [OUT_LEN-1:0]   q_d;
  logic [WW-1:0]        acc_lane;
  logic [PACK-1:0]      keep_mask;
  logic                 word_done;

  // Everything advances unless a presented word is being held back.
  assign en      = !(valid_o && !ready_i);
  assign ready_o = en;

  // Multiply, round-half-up shift and saturate; lane insertion and keep mask.
  always_comb begin
    data_ext  = PW'($signed(data_i));
    scale_ext = PW'($signed({1'b0, scale_i}));
    prod_d    = data_ext * scale_ext;

    rnd     = (shift_i == '0) ? '0 : RW'(RW'(1) << (shift_i - 1'b1));
    sum     = RW'(s1_prod_q) + rnd;
    shifted = sum >>> shift_i;
    if (shifted > QMAX) begin
      q_d = QMAX[OUT_LEN-1:0];
    end else if (shifted < QMIN) begin
      q_d = QMIN[OUT_LEN-1:0];
    end else begin
      q_d = shifted[OUT_LEN-1:0];
    end

    acc_lane  = acc_q;
    keep_mask = '0;
    for (int k = 0; k < int'(PACK); k++) begin
      if (k == int'(cnt_q)) acc_lane[k*OUT_LEN +: OUT_LEN] = s2_q;
      keep_mask[k] = (k <= int'(cnt_q));
    end
    word_done = (cnt_q == CW'(PACK - 1)) || s2_last_q;
  end

  // Pipeline stages, packer state and registered output word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_prod_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_q       <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      data_o     <= '0;
      keep_o     <= '0;
      last_o     <= 1'b0;
      valid_o    <= 1'b0;
    end else if (en) begin
      s1_valid_q <= valid_i;
      s1_last_q  <= last_i;
      s1_prod_q  <= prod_d;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_q       <= q_d;
      if (s2_valid_q && word_done) begin
        data_o  <= acc_lane;
        keep_o  <= keep_mask;
        last_o  <= s2_last_q;
        valid_o <= 1'b1;
        acc_q   <= '0;
        cnt_q   <= '0;
      end else begin
        // en implies any presented word was just accepted.
        valid_o <= 1'b0;
        if (s2_valid_q) begin
          acc_q <= acc_lane;
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule
